ripple_adder: RTL and testbench

- Registered WIDTH-bit ripple-carry adder: o = a + b + cin, carry-out on cout.
- Built as a chain of 1-bit full adders. The sum and carry are captured in an output register on the rising clock edge.
- Used as a small arithmetic leaf block wherever a registered adder with explicit carry-in/carry-out is needed.

---
 rtl/ripple_adder_pkg.sv | 16 +
 rtl/ripple_adder_full_adder.sv | 17 +
 rtl/ripple_adder.sv | 85 ++++++++
 tb/tb_ripple_adder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/ripple_adder_pkg.sv
// Shared constants and golden add function for ripple_adder.
// RIPPLE_ADDER_OVF_EN enables the registered signed-overflow port.
package ripple_adder_pkg;

  localparam int RIPPLE_ADDER_DEFAULT_WIDTH = 4;

  // Returns {cout,o} zero-extended to 33 bits; callers slice to WIDTH+1.
  function automatic logic [32:0] ref_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        cin
  );
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

endpackage

// File: rtl/ripple_adder_full_adder.sv
// One-bit combinational full adder, the cell of the ripple chain.
// RIPPLE_ADDER_OVF_EN does not affect this cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry in/out.
// Define RIPPLE_ADDER_OVF_EN to add the registered ovf output.
module ripple_adder
  import ripple_adder_pkg::*;
#(
  parameter int WIDTH = RIPPLE_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] o,
  output logic             cout,
`ifdef RIPPLE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             vld_q, vld_d;

  always_comb begin
    o_d    = o_q;
    cout_d = cout_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      o_d    = s;
      cout_d = c[WIDTH];
      vld_d  = 1'b1;
    end
  end

  // Reset wins over in_valid, so a pending op is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign o         = o_q;
  assign cout      = cout_q;
  assign out_valid = vld_q;

`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = c[WIDTH] ^ c[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder (WIDTH=4), directed plus random.
// Honours RIPPLE_ADDER_OVF_EN to also check the ovf output.
module tb_ripple_adder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] o;
  logic         cout;
  logic         out_valid;
`ifdef RIPPLE_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int errors  = 0;

  int exp_o    = 0;
  int exp_c    = 0;
  int exp_v    = 0;
  int exp_ovf  = 0;

  always #5 clk = ~clk;

  ripple_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .o         (o),
    .cout      (cout),
`ifdef RIPPLE_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, update the model, compare after the edge.
  task automatic step(input logic r, input logic v, input int ai,
                      input int bi, input logic ci, input string tag);
    int sum, sa, sb, ss;
    rst_n    = r;
    in_valid = v;
    a        = W'(ai);
    b        = W'(bi);
    cin      = ci;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_o = 0; exp_c = 0; exp_v = 0; exp_ovf = 0;
    end else if (v) begin
      sum   = ai + bi + int'(ci);
      exp_o = sum % M;
      exp_c = sum / M;
      exp_v = 1;
      sa    = (ai >= M / 2) ? ai - M : ai;
      sb    = (bi >= M / 2) ? bi - M : bi;
      ss    = sa + sb + int'(ci);
      exp_ovf = (ss > M / 2 - 1 || ss < -(M / 2)) ? 1 : 0;
    end else begin
      exp_v = 0;
    end
    vectors++;
    chk({tag, ".o"},    32'(o),         32'(exp_o));
    chk({tag, ".cout"}, 32'(cout),      32'(exp_c));
    chk({tag, ".vld"},  32'(out_valid), 32'(exp_v));
`ifdef RIPPLE_ADDER_OVF_EN
    chk({tag, ".ovf"},  32'(ovf),       32'(exp_ovf));
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;

    step(1'b0, 1'b1, 5, 3, 1'b0, "rst0");
    step(1'b0, 1'b1, 5, 3, 1'b0, "rst1");

    for (int i = 0; i < M; i++) step(1'b1, 1'b1, 0, i, 1'b0, "sweep");

    step(1'b1, 1'b1, 15, 1, 1'b0, "wrap");
    step(1'b1, 1'b1, 15, 15, 1'b1, "max");
    step(1'b1, 1'b1, 8, 7, 1'b1, "chain");

    step(1'b1, 1'b1, 2, 3, 1'b0, "hold_set");
    step(1'b1, 1'b0, 9, 9, 1'b0, "hold0");
    step(1'b1, 1'b0, 9, 9, 1'b1, "hold1");

    step(1'b1, 1'b1, 4, 4, 1'b0, "pre_rst");
    step(1'b0, 1'b1, 6, 6, 1'b0, "mid_rst");
    step(1'b1, 1'b1, 6, 6, 1'b0, "post_rst");

    step(1'b1, 1'b1, 7, 1, 1'b0, "ovf_pos");
    step(1'b1, 1'b1, 8, 8, 1'b0, "ovf_neg");
    step(1'b1, 1'b1, 3, 2, 1'b0, "ovf_none");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
           1'($urandom_range(0, 1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
